// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and the default-width payload carried between pipeline stages.
package cordic_pkg;

    localparam int          DATA_W        = 32;
    localparam int          TAG_W_DEF     = 8;
    localparam int          Q_FRAC        = 30;
    localparam logic [31:0] ANGLE_HALF_PI = 32'h4000_0000;
    localparam logic [31:0] ANGLE_PI      = 32'h8000_0000;
    localparam logic [31:0] CORDIC_K_INV  = 32'h26DD_3B6A;

    typedef struct packed {
        logic [DATA_W-1:0]    x;
        logic [DATA_W-1:0]    y;
        logic [DATA_W-1:0]    theta;
        logic [1:0]           quad;
        logic [TAG_W_DEF-1:0] tag;
    } cordic_payload_t;

endpackage

// File: rtl/cordic_skid_buffer.sv
// Two-entry register slice: output register plus one skid entry; in_ready is purely registered.
// Latency 1 cycle; absorbs one extra sample when the output stalls, no bubbles at full rate.
module cordic_skid_buffer #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data,
    output logic [1:0]    occupancy
);

    logic          skid_valid;
    logic [PW-1:0] skid_data;
    logic          in_xfer;
    logic          out_free;

    assign in_ready  = !rst && !skid_valid;
    assign in_xfer   = in_valid && in_ready;
    assign out_free  = !out_valid || out_ready;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_free) begin
            // Skid entry is older than anything on the input, and in_ready is low while it is held.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/cordic_quadrant_map.sv
// Folds a full-circle angle into +-pi/2 and emits the gain-compensated start vector and residual angle.
// Latency 1 cycle; 2-entry skid buffer keeps 1 result/cycle and stalls without bubbles.
module cordic_quadrant_map
    import cordic_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               TAG_W  = 8,
    parameter logic [WIDTH-1:0] K_INIT = WIDTH'(CORDIC_K_INV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_theta,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_theta,
    output logic [1:0]       out_quad,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);

    localparam logic [WIDTH-1:0] QUARTER_TURN = {2'b01, {(WIDTH-2){1'b0}}};
    localparam int               PW           = 3 * WIDTH + 2 + TAG_W;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] theta;
        logic [1:0]       quad;
        logic [TAG_W-1:0] tag;
    } payload_t;

    payload_t mapped;
    payload_t held;

    always_comb begin
        mapped       = '0;
        mapped.quad  = in_theta[WIDTH-1 -: 2];
        mapped.tag   = in_tag;
        mapped.theta = in_theta;
        mapped.x     = K_INIT;
        unique case (mapped.quad)
            2'b01: begin
                mapped.x     = '0;
                mapped.y     = K_INIT;
                mapped.theta = in_theta - QUARTER_TURN;
            end
            2'b10: begin
                mapped.x     = '0;
                mapped.y     = -K_INIT;
                mapped.theta = in_theta + QUARTER_TURN;
            end
            default: ;
        endcase
    end

    cordic_skid_buffer #(
        .PW(PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (mapped),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held),
        .occupancy (occupancy)
    );

    assign out_x     = held.x;
    assign out_y     = held.y;
    assign out_theta = held.theta;
    assign out_quad  = held.quad;
    assign out_tag   = held.tag;

endmodule

// File: tb/tb_cordic_quadrant_map.sv
module tb_cordic_quadrant_map;

    localparam logic [31:0] K     = 32'h26DD_3B6A;
    localparam logic [31:0] K_NEG = 32'hD922_C496;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] th;
        logic [1:0]  quad;
        logic [7:0]  tag;
    } rec_t;

    typedef struct {
        logic [31:0] theta;
        rec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_theta;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_theta;
    logic [1:0]  out_quad;
    logic [7:0]  out_tag;
    logic [1:0]  occupancy;

    int   tests = 0;
    int   fails = 0;
    rec_t sb[$];
    rec_t cur;
    int   out_count = 0;
    bit   saw_full = 0;
    bit   prev_stall = 0;
    logic [31:0] p_x, p_y, p_th;
    logic [1:0]  p_q;
    logic [7:0]  p_tag;

    always #5 clk = ~clk;

    cordic_quadrant_map dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_theta  (in_theta),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_theta (out_theta),
        .out_quad  (out_quad),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference mapping written from the angle ranges, signed comparisons on the angle.
    function automatic rec_t model(input logic [31:0] th, input logic [7:0] tg);
        rec_t r;
        int   s;
        s      = int'(th);
        r.quad = 2'(th >> 30);
        r.tag  = tg;
        if (s >= 32'sh4000_0000) begin
            r.x = 32'h0; r.y = K;     r.th = th - 32'h4000_0000;
        end else if (s < -32'sh4000_0000) begin
            r.x = 32'h0; r.y = K_NEG; r.th = th + 32'h4000_0000;
        end else begin
            r.x = K;     r.y = 32'h0; r.th = th;
        end
        return r;
    endfunction

    // Scoreboard and handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_during_rst", in_ready, 1'b0);
            sb.delete();
            prev_stall = 0;
        end else begin
            check("occupancy", occupancy, sb.size());
            check("in_ready", in_ready, sb.size() < 2);
            check("out_valid", out_valid, sb.size() > 0);
            if (sb.size() == 2) saw_full = 1;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_x", out_x, p_x);
                check("stall_y", out_y, p_y);
                check("stall_theta", out_theta, p_th);
                check("stall_quad", out_quad, p_q);
                check("stall_tag", out_tag, p_tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    rec_t e;
                    e = sb.pop_front();
                    check("out_x", out_x, e.x);
                    check("out_y", out_y, e.y);
                    check("out_theta", out_theta, e.th);
                    check("out_quad", out_quad, e.quad);
                    check("out_tag", out_tag, e.tag);
                    out_count++;
                end
            end
            if (in_valid && in_ready) sb.push_back(cur);
            prev_stall = out_valid && !out_ready;
            p_x = out_x; p_y = out_y; p_th = out_theta; p_q = out_quad; p_tag = out_tag;
        end
    end

    // Entered and left at posedge+1; holds the sample until it is accepted.
    task automatic push_sample(input logic [31:0] th, input rec_t e);
        bit acc;
        int n;
        in_valid = 1'b1; in_theta = th; in_tag = e.tag; cur = e;
        acc = 0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end
        check("accept_timeout", acc, 1'b1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h2000_0000, '{K,     32'h0, 32'h2000_0000, 2'd0, 8'd10}};
        vecs[1] = '{32'h6000_0000, '{32'h0, K,     32'h2000_0000, 2'd1, 8'd11}};
        vecs[2] = '{32'h8000_0000, '{32'h0, K_NEG, 32'hC000_0000, 2'd2, 8'd12}};
        vecs[3] = '{32'h4000_0000, '{32'h0, K,     32'h0000_0000, 2'd1, 8'd13}};
        vecs[4] = '{32'hC000_0000, '{K,     32'h0, 32'hC000_0000, 2'd3, 8'd14}};
        vecs[5] = '{32'h0000_0000, '{K,     32'h0, 32'h0000_0000, 2'd0, 8'd15}};
        vecs[6] = '{32'h3FFF_FFFF, '{K,     32'h0, 32'h3FFF_FFFF, 2'd0, 8'd16}};
        vecs[7] = '{32'h7FFF_FFFF, '{32'h0, K,     32'h3FFF_FFFF, 2'd1, 8'd17}};
        vecs[8] = '{32'hBFFF_FFFF, '{32'h0, K_NEG, 32'hFFFF_FFFF, 2'd2, 8'd18}};
        vecs[9] = '{32'hFFFF_FFFF, '{K,     32'h0, 32'hFFFF_FFFF, 2'd3, 8'd19}};

        rst = 1'b1; in_valid = 1'b0; in_theta = '0; in_tag = '0; out_ready = 1'b1;
        cur = model(32'h0, 8'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_out_x", out_x, 32'h0);
        check("rst_out_y", out_y, 32'h0);
        check("rst_out_theta", out_theta, 32'h0);
        check("rst_out_quad", out_quad, 2'd0);
        check("rst_out_tag", out_tag, 8'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk); #1;

        // First vector alone: latency 1 into an empty pipe.
        push_sample(vecs[0].theta, vecs[0].exp);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency1_valid", out_valid, 1'b1);
        check("latency1_x", out_x, K);
        @(posedge clk); #1;

        // Remaining boundary vectors back-to-back.
        for (int i = 1; i < 10; i++) push_sample(vecs[i].theta, vecs[i].exp);
        drain();

        // Tags 1..8 streamed with out_ready low for cycles 3-5.
        begin
            int t, cyc;
            bit acc;
            t = 1; cyc = 1; saw_full = 0; out_count = 0;
            in_valid = 1'b1; in_theta = 32'h1000_0000 * 32'(t); in_tag = 8'(t);
            cur = model(in_theta, in_tag);
            while (t <= 8 && cyc < 60) begin
                out_ready = !(cyc >= 3 && cyc <= 5);
                @(negedge clk); acc = in_valid && in_ready;
                @(posedge clk); #1; cyc++;
                if (acc) begin
                    t++;
                    in_theta = 32'h1000_0000 * 32'(t); in_tag = 8'(t);
                    cur = model(in_theta, in_tag);
                end
            end
            check("stream_all_accepted", t, 9);
            drain();
            check("stream_saw_full", saw_full, 1'b1);
            check("stream_out_count", out_count, 8);
        end

        // Reset while both entries are held.
        out_ready = 1'b0;
        push_sample(32'h9000_0000, model(32'h9000_0000, 8'hA1));
        push_sample(32'h5000_0000, model(32'h5000_0000, 8'hA2));
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_occupancy", occupancy, 2'd2);
        @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_occupancy", occupancy, 2'd0);
        check("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        push_sample(32'hE000_0000, model(32'hE000_0000, 8'hB0));
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_latency_valid", out_valid, 1'b1);
        check("post_rst_latency_tag", out_tag, 8'hB0);
        @(posedge clk); #1;
        drain();

        // Random angles with random valid/ready.
        begin
            int sent, cyc;
            bit acc;
            sent = 0; cyc = 0; in_valid = 1'b0;
            while (sent < 3000 && cyc < 30000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (!in_valid && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1; in_theta = $urandom; in_tag = 8'(sent);
                    cur = model(in_theta, in_tag);
                end
                @(negedge clk); acc = in_valid && in_ready;
                @(posedge clk); #1; cyc++;
                if (acc) begin
                    sent++;
                    in_valid = 1'b0;
                end
            end
            check("random_all_sent", sent, 3000);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
